// File: rtl/noc_leaf_injector.sv
// -----------------------------------------------------------------------------
// noc_leaf_injector
//
// Leaf-side injection stage of the NoC reduction tree. Words from a
// processing element are buffered in a small single-clock FIFO, stamped with
// a static source ID and presented to one input of the first-level merge
// stage. A one-cycle gap is forced after every max_burst pops so a single
// leaf cannot monopolise its merge input.
//
// Handshake: the PE side is strict valid/ready. A word transfers on a rising
// edge where pe_valid & pe_ready; pe_ready depends only on the registered
// occupancy, never on pe_valid. Downstream there is no ready: the merge stage
// loads whenever the validity bit of out is set, and full blocks emission
// combinationally in the same cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pe_valid   PE offers pe_data
//   pe_data    PE payload (data_width bits)
//   pe_ready   a word can be accepted this cycle
//   full       backpressure from the downstream merge input
//   out        {valid, src_id, data}; all zeros while the FIFO is empty
//   sent_cnt   words emitted, saturating (INJ_STATS_EN only)
//   stall_cnt  backpressure stall cycles, saturating (INJ_STATS_EN only)
//   state_dbg  current FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Optional feature macro: INJ_STATS_EN adds the two statistics counters.
// -----------------------------------------------------------------------------
module noc_leaf_injector #(
  parameter int word_width     = 16,
  parameter int val_bit        = 1,
  parameter int id_width       = 3,
  parameter int src_id         = 0,
  parameter int log_buffer_len = 3,
  parameter int max_burst      = 4,
  localparam int data_width    = word_width - val_bit - id_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_valid,
  input  logic [data_width-1:0] pe_data,
  output logic                  pe_ready,
  input  logic                  full,
  output logic [word_width-1:0] out,
`ifdef INJ_STATS_EN
  output logic [15:0]           sent_cnt,
  output logic [15:0]           stall_cnt,
`endif
  output logic [1:0]            state_dbg
);

  localparam int depth = 1 << log_buffer_len;
  localparam int cw    = log_buffer_len + 1;
  localparam int bw    = $clog2(max_burst + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                    state;
  logic [data_width-1:0]     mem [depth];
  logic [log_buffer_len-1:0] wr_ptr;
  logic [log_buffer_len-1:0] rd_ptr;
  logic [cw-1:0]             count;
  logic [cw-1:0]             count_nxt;
  logic [bw-1:0]             burst_cnt;
  logic [bw-1:0]             burst_nxt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      can_send;

  assign fifo_full  = (count == cw'(depth));
  assign fifo_empty = (count == '0);
  assign pe_ready   = !fifo_full;
  assign push       = pe_valid & pe_ready;
  assign can_send   = (state == SEND) & !fifo_empty & !full;
  assign pop        = can_send;
  assign count_nxt  = count + cw'(push) - cw'(pop);
  assign burst_nxt  = burst_cnt + 1'b1;
  assign state_dbg  = state;

  // Whole word is zero when nothing is buffered; otherwise the head is shown
  // even while stalled, with the validity bit carrying the emit decision.
  assign out = fifo_empty ? '0
                          : {{val_bit{can_send}}, id_width'(src_id), mem[rd_ptr]};

  // FIFO storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pe_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Control FSM. Decisions use the post-edge occupancy so a push landing in
  // the same cycle as the last pop keeps the block in SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (count_nxt != '0) state <= SEND;
        end
        SEND: begin
          if (pop) begin
            if ((max_burst != 0) && (burst_nxt == bw'(max_burst))) begin
              state     <= GAP;
              burst_cnt <= '0;
            end else if (count_nxt == '0) begin
              state     <= IDLE;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_nxt;
            end
          end
        end
        GAP: begin
          burst_cnt <= '0;
          state     <= (count_nxt != '0) ? SEND : IDLE;
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

`ifdef INJ_STATS_EN
  logic stall;
  assign stall = (state == SEND) & !fifo_empty & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (sent_cnt != 16'hFFFF))    sent_cnt  <= sent_cnt + 16'd1;
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_leaf_injector.sv
// -----------------------------------------------------------------------------
// tb_noc_leaf_injector
//
// Directed bench for noc_leaf_injector with src_id=5, max_burst=4, depth 8.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// 3 time units after the edge, well before the next one.
// -----------------------------------------------------------------------------
module tb_noc_leaf_injector;

  localparam int W  = 16;
  localparam int DW = 12;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          pe_valid = 1'b0;
  logic [DW-1:0] pe_data  = '0;
  logic          full     = 1'b0;
  logic          pe_ready;
  logic [W-1:0]  out;
  logic [1:0]    state_dbg;
`ifdef INJ_STATS_EN
  logic [15:0]   sent_cnt;
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  noc_leaf_injector #(
    .word_width(16), .val_bit(1), .id_width(3), .src_id(5),
    .log_buffer_len(3), .max_burst(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pe_valid(pe_valid),
    .pe_data(pe_data),
    .pe_ready(pe_ready),
    .full(full),
    .out(out),
`ifdef INJ_STATS_EN
    .sent_cnt(sent_cnt),
    .stall_cnt(stall_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    pe_valid = v;
    pe_data  = d;
  endtask

  // checker
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // expected word builders: valid / stalled-with-head (id 5 = 3'b101)
  function automatic logic [15:0] vw(input logic [11:0] d);
    return {1'b1, 3'd5, d};
  endfunction

  function automatic logic [15:0] iw(input logic [11:0] d);
    return {1'b0, 3'd5, d};
  endfunction

  initial begin
    // ---------------- reset ----------------
    drive(1'b1, 12'hABC);
    full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      check("rst_out", out, 16'h0000);
      check("rst_rdy", {15'b0, pe_ready}, 16'd1);
    end
    check("rst_state", {14'b0, state_dbg}, 16'd0);
`ifdef INJ_STATS_EN
    check("rst_sent", sent_cnt, 16'd0);
    check("rst_stall", stall_cnt, 16'd0);
`endif
    cyc();
    rst_n = 1'b1;
    drive(1'b0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      check("post_rst_out", out, 16'h0000);
      check("post_rst_state", {14'b0, state_dbg}, 16'd0);
    end

    // ---------------- single word ----------------
    cyc(); drive(1'b1, 12'h123); settle();
    check("single_pre", out, 16'h0000);
    check("single_rdy", {15'b0, pe_ready}, 16'd1);
    cyc(); drive(1'b0, 12'h000); settle();
    check("single_out", out, 16'hD123);
    cyc(); settle();
    check("single_after", out, 16'h0000);
    check("single_idle", {14'b0, state_dbg}, 16'd0);

    // ---------------- burst gap ----------------
    cyc(); drive(1'b1, 12'h301); settle();
    check("burst_c0", out, 16'h0000);
    cyc(); drive(1'b1, 12'h302); settle(); check("burst_c1", out, vw(12'h301));
    cyc(); drive(1'b1, 12'h303); settle(); check("burst_c2", out, vw(12'h302));
    cyc(); drive(1'b1, 12'h304); settle(); check("burst_c3", out, vw(12'h303));
    cyc(); drive(1'b1, 12'h305); settle(); check("burst_c4", out, vw(12'h304));
    cyc(); drive(1'b1, 12'h306); settle();
    check("burst_gap", out, iw(12'h305));
    check("burst_gap_state", {14'b0, state_dbg}, 16'd2);
    cyc(); drive(1'b0, 12'h000); settle(); check("burst_c6", out, vw(12'h305));
    cyc(); settle(); check("burst_c7", out, vw(12'h306));
    cyc(); settle(); check("burst_c8", out, 16'h0000);

    // ---------------- backpressure (fresh counters) ----------------
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    full = 1'b1;
    drive(1'b1, 12'h401); settle();
    check("bp_b0", out, 16'h0000);
    cyc(); drive(1'b1, 12'h402); settle(); check("bp_b1", out, iw(12'h401));
    cyc(); drive(1'b1, 12'h403); settle(); check("bp_b2", out, iw(12'h401));
    cyc(); drive(1'b0, 12'h000); settle(); check("bp_b3", out, iw(12'h401));
    cyc(); settle(); check("bp_b4", out, iw(12'h401));
    cyc(); settle(); check("bp_b5", out, iw(12'h401));
    cyc(); full = 1'b0; settle(); check("bp_b6", out, vw(12'h401));
    cyc(); settle(); check("bp_b7", out, vw(12'h402));
    cyc(); settle(); check("bp_b8", out, vw(12'h403));
    cyc(); settle(); check("bp_b9", out, 16'h0000);
`ifdef INJ_STATS_EN
    check("bp_sent", sent_cnt, 16'd3);
    check("bp_stall", stall_cnt, 16'd5);
`endif

    // ---------------- FIFO full ----------------
    cyc(); full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      drive(1'b1, 12'h501 + 12'(i));
      settle();
      check("ff_rdy_fill", {15'b0, pe_ready}, 16'd1);
    end
    cyc(); drive(1'b1, 12'h509); full = 1'b0; settle();
    check("ff_rdy_full", {15'b0, pe_ready}, 16'd0);
    check("ff_pop", out, vw(12'h501));
    cyc(); full = 1'b1; settle();
    check("ff_rdy_back", {15'b0, pe_ready}, 16'd1);
    check("ff_stalled", out, iw(12'h502));
    cyc(); drive(1'b0, 12'h000); full = 1'b0; settle(); check("ff_502", out, vw(12'h502));
    cyc(); settle(); check("ff_503", out, vw(12'h503));
    cyc(); settle(); check("ff_504", out, vw(12'h504));
    cyc(); settle(); check("ff_gap1", out, iw(12'h505));
    cyc(); settle(); check("ff_505", out, vw(12'h505));
    cyc(); settle(); check("ff_506", out, vw(12'h506));
    cyc(); settle(); check("ff_507", out, vw(12'h507));
    cyc(); settle(); check("ff_508", out, vw(12'h508));
    cyc(); settle(); check("ff_gap2", out, iw(12'h509));
    cyc(); settle(); check("ff_509", out, vw(12'h509));
    cyc(); settle(); check("ff_end", out, 16'h0000);

    // ---------------- mid-operation reset ----------------
    cyc(); full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) cyc();
      drive(1'b1, 12'h601 + 12'(i));
    end
    cyc(); drive(1'b0, 12'h000); settle();
    check("mr_held", out, iw(12'h601));
    rst_n = 1'b0;
    #1;
    check("mr_out_now", out, 16'h0000);
    check("mr_rdy_now", {15'b0, pe_ready}, 16'd1);
    check("mr_state_now", {14'b0, state_dbg}, 16'd0);
    full = 1'b0;
    cyc();
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      check("mr_no_stale", out, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
